hazard_forward_scheduler: RTL

HAZARD_FORWARD_SCHEDULER -- requirements
Module: hazard_forward_scheduler

---
 rtl/hazard_forward_scheduler.sv | 126 ++++++++++++
 1 files changed

// File: rtl/hazard_forward_scheduler.sv
// Hazard/forwarding scheduler: selects registered one cycle ahead of EXE, stall combinational,
// mem_ready=0 freezes all tracking. Forwarding selected by FORWARDING_UNIT_EN (default: stall-only).
module hazard_forward_scheduler (
   input  logic        clk,
   input  logic        rst,
   input  logic        id_valid,
   input  logic [3:0]  id_src1,
   input  logic [3:0]  id_src2,
   input  logic        id_two_src,
   input  logic [3:0]  id_dest,
   input  logic        id_wb_en,
   input  logic        id_mem_r_en,
   input  logic        mem_ready,
   output logic [1:0]  sel_src1,
   output logic [1:0]  sel_src2,
   output logic        hazard_stall,
   output logic        freeze,
   output logic [1:0]  state,
   output logic [15:0] stall_cnt
);
   typedef enum logic [1:0] {RUN = 2'b00, HAZ = 2'b01, WAIT = 2'b10} state_t;

   state_t     state_q;
   logic       exe_v, exe_wb, exe_mr;
   logic [3:0] exe_dest;
   logic       mem_v, mem_wb, mem_mr;
   logic [3:0] mem_dest;
   logic       wb_v, wb_wb;
   logic [3:0] wb_dest;
   logic       src1_exe, src2_exe, src1_mem, src2_mem, exe_hit;

   assign src1_exe = exe_v & exe_wb & (exe_dest == id_src1);
   assign src2_exe = id_two_src & exe_v & exe_wb & (exe_dest == id_src2);
   assign src1_mem = mem_v & mem_wb & (mem_dest == id_src1);
   assign src2_mem = id_two_src & mem_v & mem_wb & (mem_dest == id_src2);
   assign exe_hit  = src1_exe | src2_exe;

   assign freeze = ~mem_ready;
   assign state  = state_q;

`ifdef FORWARDING_UNIT_EN
   assign hazard_stall = id_valid & mem_ready & exe_hit & exe_mr;
`else
   assign hazard_stall = id_valid & mem_ready & (exe_hit | src1_mem | src2_mem);
`endif

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         exe_v    <= 1'b0;
         exe_wb   <= 1'b0;
         exe_mr   <= 1'b0;
         exe_dest <= 4'd0;
         mem_v    <= 1'b0;
         mem_wb   <= 1'b0;
         mem_mr   <= 1'b0;
         mem_dest <= 4'd0;
         wb_v     <= 1'b0;
         wb_wb    <= 1'b0;
         wb_dest  <= 4'd0;
      end else if (mem_ready) begin
         wb_v     <= mem_v;
         wb_wb    <= mem_wb;
         wb_dest  <= mem_dest;
         mem_v    <= exe_v;
         mem_wb   <= exe_wb;
         mem_mr   <= exe_mr;
         mem_dest <= exe_dest;
         exe_v    <= id_valid & ~hazard_stall;
         exe_wb   <= id_wb_en;
         exe_mr   <= id_mem_r_en;
         exe_dest <= id_dest;
      end
   end

   // WAIT always wins; leaving WAIT goes through RUN before a hazard can show as HAZ.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state_q   <= RUN;
         stall_cnt <= 16'd0;
      end else begin
         if (!mem_ready)
            state_q <= WAIT;
         else if (state_q == WAIT)
            state_q <= RUN;
         else if (hazard_stall)
            state_q <= HAZ;
         else
            state_q <= RUN;
         if ((hazard_stall || freeze) && stall_cnt != 16'hFFFF)
            stall_cnt <= stall_cnt + 16'd1;
      end
   end

`ifdef FORWARDING_UNIT_EN
   // A loaded EXE hit never reaches here: it stalls and the bubble loads 00.
   function automatic logic [1:0] pick(input logic hit_exe, input logic hit_mem,
                                       input logic exe_load);
      pick = (hit_exe && !exe_load) ? 2'b01 : (hit_mem ? 2'b10 : 2'b00);
   endfunction

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         sel_src1 <= 2'b00;
         sel_src2 <= 2'b00;
      end else if (mem_ready) begin
         if (id_valid && !hazard_stall) begin
            sel_src1 <= pick(src1_exe, src1_mem, exe_mr);
            sel_src2 <= pick(src2_exe, src2_mem, exe_mr);
         end else begin
            sel_src1 <= 2'b00;
            sel_src2 <= 2'b00;
         end
      end
   end

   // WB hits read the register file directly, so WB tracking never drives an output.
   logic unused_stage;
   assign unused_stage = ^{mem_mr, wb_v, wb_wb, wb_dest};
`else
   assign sel_src1 = 2'b00;
   assign sel_src2 = 2'b00;

   logic unused_stage;
   assign unused_stage = ^{exe_mr, mem_mr, wb_v, wb_wb, wb_dest};
`endif
endmodule
